spi_reg_master: RTL and testbench

- Initiator for the board's SPI register protocol. Each frame carries an 8-bit address (MSB = read flag), then DUMMY_CYCLES idle clocks, then a 16-bit data word, all MSB first, in SPI mode 0.
- Converts a valid/ready register request into one frame and returns the captured MISO data.
- Drives register slaves on daughter boards and serves as a synthesizable stimulus source for the slave register interface.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_half_tick.sv | 37 +++
 rtl/spi_reg_master.sv | 145 ++++++++++++++
 tb/tb_spi_reg_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared frame geometry and FSM encoding for the SPI register initiator.
package spi_reg_pkg;

   localparam int ADDR_W        = 8;
   localparam int DATA_W        = 16;
   localparam int DUMMY_CYCLES  = 8;
   localparam int READ_FLAG_BIT = ADDR_W - 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_TAIL  = 3'd4,
      ST_GAP   = 3'd5
   } state_e;

   function automatic int frame_bits(input int aw, input int dw, input int dc);
      return aw + dc + dw;
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter: done_o is high in the last cycle of a loaded interval,
// so a load of L at one edge lets the owner act on the L-th following edge.
module spi_half_tick
   import spi_reg_pkg::*;
#(
   parameter int W       = 8,
   parameter int RST_VAL = 1
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= W'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/spi_reg_master.sv
// SPI register-frame initiator: one accepted request becomes one mode-0 frame
// (address, dummy clocks, data, MSB first); captured MISO returns on rsp_valid.
module spi_reg_master
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W       = spi_reg_pkg::ADDR_W,
   parameter int DATA_W       = spi_reg_pkg::DATA_W,
   parameter int DUMMY_CYCLES = spi_reg_pkg::DUMMY_CYCLES,
   parameter int CLK_DIV      = 2,
   parameter int CS_GAP       = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_read,
   input  logic [ADDR_W-2:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n
);

   localparam int N  = frame_bits(ADDR_W, DATA_W, DUMMY_CYCLES);
   localparam int TW = $clog2(((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP) + 1);
   localparam int BW = $clog2(N + 1);

   state_e            state_q, state_d;
   logic [N-1:0]      tx_q, tx_d;
   logic [N-1:0]      rx_q, rx_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              busy_q, busy_d;
   logic              rsp_vld_q, rsp_vld_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              tick_load, tick_done;
   logic [TW-1:0]     tick_val;

   // Reset lands in GAP so the first request waits out a full CS_GAP interval.
   spi_half_tick #(.W(TW), .RST_VAL(CS_GAP)) u_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .load_i  (tick_load),
      .val_i   (tick_val),
      .done_o  (tick_done)
   );

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_d       = bit_q;
      cs_n_d      = cs_n_q;
      sck_d       = sck_q;
      busy_d      = busy_q;
      rsp_vld_d   = 1'b0;
      rsp_addr_d  = rsp_addr_q;
      rsp_rdata_d = rsp_rdata_q;
      tick_load   = 1'b0;
      tick_val    = TW'(CLK_DIV);
      case (state_q)
         ST_IDLE: if (req_valid) begin
            // Dummy clocks keep driving the address LSB; reads send an all-zero data phase.
            tx_d      = {req_read, req_addr, {DUMMY_CYCLES{req_addr[0]}},
                         (req_read ? {DATA_W{1'b0}} : req_wdata)};
            cs_n_d    = 1'b0;
            busy_d    = 1'b1;
            bit_d     = '0;
            tick_load = 1'b1;
            state_d   = ST_SETUP;
         end
         ST_SETUP, ST_LOW: if (tick_done) begin
            sck_d     = 1'b1;
            tick_load = 1'b1;
            state_d   = ST_HIGH;
         end
         ST_HIGH: if (tick_done) begin
            sck_d     = 1'b0;
            rx_d      = {rx_q[N-2:0], spi_miso};
            tx_d      = {tx_q[N-2:0], 1'b0};
            bit_d     = bit_q + BW'(1);
            tick_load = 1'b1;
            state_d   = (bit_q == BW'(N - 1)) ? ST_TAIL : ST_LOW;
         end
         ST_TAIL: if (tick_done) begin
            cs_n_d      = 1'b1;
            tx_d        = '0;
            rsp_vld_d   = 1'b1;
            rsp_addr_d  = rx_q[N-1 -: ADDR_W];
            rsp_rdata_d = rx_q[DATA_W-1:0];
            tick_load   = 1'b1;
            tick_val    = TW'(CS_GAP);
            state_d     = ST_GAP;
         end
         ST_GAP: if (tick_done) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_GAP;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_GAP;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         cs_n_q      <= 1'b1;
         sck_q       <= 1'b0;
         busy_q      <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         busy_q      <= busy_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_vld_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;
   assign spi_clk   = sck_q;
   assign spi_mosi  = tx_q[N-1];
   assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a CLK_DIV=2 instance with a behavioural SPI slave and
// a CLK_DIV=1 instance with MISO looped back from MOSI.
module tb_spi_reg_master;

   localparam int CD0 = 2;
   localparam int CD1 = 1;
   localparam int GAP = 4;
   localparam int NB  = 32;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic        req_valid = 1'b0, req_valid1 = 1'b0, req_read = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        spi_miso = 1'b0;

   logic        req_ready, rsp_valid, busy, spi_clk, spi_mosi, spi_cs_n;
   logic [7:0]  rsp_addr;
   logic [15:0] rsp_rdata;
   logic        req_ready1, rsp_valid1, busy1, spi_clk1, spi_mosi1, spi_cs1_n;
   logic [7:0]  rsp_addr1;
   logic [15:0] rsp_rdata1;

   spi_reg_master #(.CLK_DIV(CD0), .CS_GAP(GAP)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_read(req_read), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .busy(busy),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n));

   spi_reg_master #(.CLK_DIV(CD1), .CS_GAP(GAP)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_read(req_read), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_addr(rsp_addr1), .rsp_rdata(rsp_rdata1), .busy(busy1),
      .spi_clk(spi_clk1), .spi_mosi(spi_mosi1), .spi_miso(spi_mosi1), .spi_cs_n(spi_cs1_n));

   // Observation mux so one frame task serves both instances.
   logic        sel = 1'b0;
   logic        o_cs, o_sck, o_mosi, o_rsp, o_busy, o_ready;
   logic [7:0]  o_ra;
   logic [15:0] o_rd;
   assign o_cs    = sel ? spi_cs1_n  : spi_cs_n;
   assign o_sck   = sel ? spi_clk1   : spi_clk;
   assign o_mosi  = sel ? spi_mosi1  : spi_mosi;
   assign o_rsp   = sel ? rsp_valid1 : rsp_valid;
   assign o_busy  = sel ? busy1      : busy;
   assign o_ready = sel ? req_ready1 : req_ready;
   assign o_ra    = sel ? rsp_addr1  : rsp_addr;
   assign o_rd    = sel ? rsp_rdata1 : rsp_rdata;

   // Mode-0 slave: presents bit 0 at CS fall, advances on SCK fall, captures MOSI on SCK rise.
   // Mode 1 echoes the data word captured in the previous complete frame.
   logic        slave_mode = 1'b0;
   logic [31:0] resp_word = '0;
   logic [31:0] cur_resp = '0, cap = '0;
   logic [15:0] echo_word = '0;
   logic        s_pcs = 1'b1, s_psck = 1'b0;
   int          s_bit = 0, ncap = 0;

   always @(negedge sys_clk) begin
      if (!slave_mode) echo_word = 16'h0;
      if (s_pcs && !spi_cs_n) begin
         cur_resp = slave_mode ? {16'h0, echo_word} : resp_word;
         s_bit    = 0;
         ncap     = 0;
         cap      = '0;
         spi_miso = cur_resp[31];
      end else if (!spi_cs_n && s_psck && !spi_clk) begin
         s_bit++;
         spi_miso = (s_bit < 32) ? cur_resp[5'(31 - s_bit)] : 1'b0;
      end
      if (!spi_cs_n && !s_psck && spi_clk) begin
         cap = {cap[30:0], spi_mosi};
         ncap++;
      end
      if (!s_pcs && spi_cs_n) begin
         if (ncap == 32 && slave_mode) echo_word = cap[15:0];
         spi_miso = 1'b0;
      end
      s_pcs  = spi_cs_n;
      s_psck = spi_clk;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int w;
      w = 0;
      while (!o_ready && w < 500) begin
         @(negedge sys_clk);
         w++;
      end
      check({tag, ".ready_wait"}, 32'(w < 500), 32'd1);
   endtask

   task automatic run_frame(input logic s, input logic rd, input logic [6:0] a, input logic [15:0] wd,
                            output logic [31:0] mbits, output int nb, output int cs_low, output int lat,
                            output int pulses, output logic [7:0] ra, output logic [15:0] rdat,
                            output int per_bad, output int busy_bad);
      int t, last_rise, cd;
      logic pclk;
      sel = s;
      cd  = s ? CD1 : CD0;
      @(negedge sys_clk);
      wait_ready("frame");
      req_read  = rd;
      req_addr  = a;
      req_wdata = wd;
      if (s) req_valid1 = 1'b1;
      else   req_valid  = 1'b1;
      @(negedge sys_clk);
      req_valid  = 1'b0;
      req_valid1 = 1'b0;
      req_read   = 1'($urandom);
      req_addr   = 7'($urandom);
      req_wdata  = 16'($urandom);
      mbits = '0; nb = 0; cs_low = 0; lat = -1; pulses = 0; ra = '0; rdat = '0;
      per_bad = 0; busy_bad = 0; last_rise = -1; pclk = 1'b0; t = 1;
      while (t < 1000) begin
         if (!o_cs) cs_low++;
         if (o_sck && !pclk) begin
            mbits = {mbits[30:0], o_mosi};
            nb++;
            if (last_rise >= 0 && (t - last_rise) != 2 * cd) per_bad++;
            last_rise = t;
         end
         if (o_rsp) begin
            pulses++;
            lat  = t;
            ra   = o_ra;
            rdat = o_rd;
         end
         if (!o_busy && !o_ready) busy_bad++;
         if (o_ready) break;
         pclk = o_sck;
         @(negedge sys_clk);
         t++;
      end
      check("frame_end_bound", 32'(t < 1000), 32'd1);
   endtask

   // Expected frame derived from the protocol: {rd, addr, 8 x addr LSB, data or 0}.
   task automatic check_frame(input string tag, input logic s, input logic rd, input logic [6:0] a,
                              input logic [15:0] wd, input logic [31:0] resp);
      logic [31:0] mbits, em;
      logic [7:0]  ra, era;
      logic [15:0] rdat, erd;
      int nb, cs_low, lat, pulses, per_bad, busy_bad, ecs;
      run_frame(s, rd, a, wd, mbits, nb, cs_low, lat, pulses, ra, rdat, per_bad, busy_bad);
      em  = {rd, a, {8{a[0]}}, (rd ? 16'h0 : wd)};
      ecs = (2 * NB + 1) * (s ? CD1 : CD0);
      if (s) begin
         era = {rd, a};
         erd = em[15:0];
      end else begin
         era = resp[31:24];
         erd = resp[15:0];
      end
      check({tag, ".mosi"},     mbits,        em);
      check({tag, ".sck_rises"}, nb,          NB);
      check({tag, ".cs_low"},   cs_low,       ecs);
      check({tag, ".latency"},  lat,          ecs + 1);
      check({tag, ".pulses"},   pulses,       1);
      check({tag, ".sck_per"},  per_bad,      0);
      check({tag, ".busy"},     busy_bad,     0);
      check({tag, ".rsp_addr"}, 32'(ra),      32'(era));
      check({tag, ".rsp_data"}, 32'(rdat),    32'(erd));
   endtask

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t, pul, acc, hi_run, min_hi, bb, nb;
      int acc_t[3];
      logic pclk, started;
      logic [15:0] prev;
      logic [15:0] words[4];
      logic        rrd;
      logic [6:0]  raddr;
      logic [15:0] rwd;

      #1 sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_outputs", 32'({spi_cs_n, spi_clk, spi_mosi, rsp_valid, busy, req_ready, rsp_addr, rsp_rdata}),
            32'({1'b1, 5'b0, 8'h00, 16'h0000}));
      check("rst_outputs1", 32'({spi_cs1_n, spi_clk1, spi_mosi1, rsp_valid1, busy1, req_ready1}), 32'(6'b100000));
      sys_rst = 1'b0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!req_ready && n < 50);
      check("ready_after_reset", n, GAP);

      slave_mode = 1'b0;
      resp_word  = $urandom;
      check_frame("wr00_aaaa", 1'b0, 1'b0, 7'h00, 16'haaaa, resp_word);

      resp_word = {8'($urandom), 8'($urandom), 16'h5555};
      check_frame("rd01", 1'b0, 1'b1, 7'h01, 16'($urandom), resp_word);

      slave_mode = 1'b1;
      prev  = 16'h0000;
      words = '{16'h8000, 16'h0001, 16'hffff, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         check_frame("echo", 1'b0, 1'b0, 7'($urandom), words[i], {16'h0, prev});
         prev = words[i];
      end
      slave_mode = 1'b0;

      for (int i = 0; i < 4; i++) begin
         rrd       = 1'($urandom);
         raddr     = 7'($urandom);
         rwd       = 16'($urandom);
         resp_word = $urandom;
         check_frame("rand", 1'b0, rrd, raddr, rwd, resp_word);
      end

      // req_valid held high across several frames.
      sel = 1'b0;
      wait_ready("b2b");
      req_read  = 1'b0;
      req_valid = 1'b1;
      acc = 0; pul = 0; hi_run = 0; min_hi = 1000; started = 1'b0; bb = 0; t = 0;
      acc_t = '{0, 0, 0};
      while (pul < 3 && t < 2000) begin
         if (req_valid && req_ready) begin
            if (acc < 3) acc_t[acc] = t;
            acc++;
         end
         if (spi_cs_n) begin
            hi_run++;
         end else begin
            if (started && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
            started = 1'b1;
            hi_run  = 0;
         end
         if (rsp_valid) pul++;
         if (!busy && !req_ready) bb++;
         req_addr  = 7'($urandom);
         req_wdata = 16'($urandom);
         @(negedge sys_clk);
         t++;
      end
      req_valid = 1'b0;
      check("b2b.bound",   32'(t < 2000), 32'd1);
      check("b2b.accepts", acc, 3);
      check("b2b.period",  acc_t[2] - acc_t[0], 2 * ((2 * NB + 1) * CD0 + GAP + 1));
      check("b2b.cs_gap",  32'(min_hi >= GAP), 32'd1);
      check("b2b.busy",    bb, 0);

      // Reset asserted at the 12th SCK rise of a frame.
      wait_ready("midrst");
      req_read  = 1'b0;
      req_addr  = 7'($urandom);
      req_wdata = 16'($urandom);
      req_valid = 1'b1;
      @(negedge sys_clk);
      req_valid = 1'b0;
      pclk = 1'b0; nb = 0; t = 0;
      while (nb < 12 && t < 500) begin
         @(negedge sys_clk);
         t++;
         if (spi_clk && !pclk) nb++;
         pclk = spi_clk;
      end
      check("midrst.bound", 32'(t < 500), 32'd1);
      sys_rst = 1'b1;
      #1;
      check("midrst.outputs", 32'({spi_cs_n, spi_clk, spi_mosi, rsp_valid, busy, req_ready}), 32'(6'b100000));
      pul = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (rsp_valid) pul++;
      end
      sys_rst = 1'b0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
         if (rsp_valid) pul++;
      end while (!req_ready && n < 50);
      check("midrst.ready", n, GAP);
      check("midrst.no_rsp", pul, 0);
      resp_word = $urandom;
      check_frame("post_rst", 1'b0, 1'b0, 7'($urandom), 16'($urandom), resp_word);

      check_frame("div1_2a2a", 1'b1, 1'b0, 7'($urandom), 16'h2a2a, 32'h0);
      check_frame("div1_rd", 1'b1, 1'b1, 7'($urandom), 16'($urandom), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
